// File: rtl/lsu_bus_adapter.sv
// Load/store bus adapter: turns RV32I byte/half/word accesses into a word-aligned valid/ready
// transaction and stalls the core until it completes. Optional trap: LSU_MISALIGN_TRAP_EN.
module lsu_bus_adapter #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              fault,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_we,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic [31:0]       bus_rdata
);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic                bus_we_q, bus_we_d;
    logic [3:0]          bus_be_q, bus_be_d;
    logic [31:0]         bus_wdata_q, bus_wdata_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [1:0]          off_q, off_d;
    logic [31:0]         rdata_q, rdata_d;

    logic [1:0]  off;
    logic        is_byte, is_half;
    logic [3:0]  be_new;
    logic [31:0] lane_data;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_ext;
    logic        sign_q;

    assign off     = addr[1:0];
    assign is_byte = (funct3[1:0] == 2'b00);
    assign is_half = (funct3[1:0] == 2'b01);

    always_comb begin
        be_new    = 4'b1111;
        lane_data = wdata;
        if (is_byte) begin
            be_new    = 4'b0001 << off;
            lane_data = {4{wdata[7:0]}};
        end else if (is_half) begin
            be_new    = off[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{wdata[15:0]}};
        end
    end

    // Load lane extraction uses the offset and size captured at issue time.
    always_comb begin
        byte_v = bus_rdata[7:0];
        unique case (off_q)
            2'd0: byte_v = bus_rdata[7:0];
            2'd1: byte_v = bus_rdata[15:8];
            2'd2: byte_v = bus_rdata[23:16];
            2'd3: byte_v = bus_rdata[31:24];
            default: byte_v = bus_rdata[7:0];
        endcase
        half_v = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    end

    assign sign_q = ~funct3_q[2];

    always_comb begin
        load_ext = bus_rdata;
        if (funct3_q[1:0] == 2'b00) begin
            load_ext = {{24{sign_q & byte_v[7]}}, byte_v};
        end else if (funct3_q[1:0] == 2'b01) begin
            load_ext = {{16{sign_q & half_v[15]}}, half_v};
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic fault_q, fault_d;
    logic misalign;

    assign misalign = (is_half & off[0]) | (~is_byte & ~is_half & (off != 2'b00));
`endif

    always_comb begin
        state_d     = state_q;
        bus_addr_d  = bus_addr_q;
        bus_we_d    = bus_we_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        rdata_d     = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
        fault_d     = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (mem_req) begin
                    bus_addr_d  = {addr[ADDR_W-1:2], 2'b00};
                    bus_we_d    = mem_we;
                    bus_be_d    = be_new;
                    bus_wdata_d = mem_we ? lane_data : 32'd0;
                    funct3_d    = funct3;
                    off_d       = off;
                    state_d     = StReq;
`ifdef LSU_MISALIGN_TRAP_EN
                    // Misaligned accesses skip the bus entirely and report through DONE.
                    if (misalign) begin
                        state_d = StDone;
                        fault_d = 1'b1;
                        rdata_d = 32'd0;
                    end
`endif
                end
            end
            StReq: begin
                if (bus_ready) begin
                    if (!bus_we_q) begin
                        rdata_d = load_ext;
                    end
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            bus_addr_q  <= '0;
            bus_we_q    <= 1'b0;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= 32'd0;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            rdata_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            bus_addr_q  <= bus_addr_d;
            bus_we_q    <= bus_we_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            rdata_q     <= rdata_d;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    assign stall     = ((state_q == StIdle) & mem_req) | (state_q == StReq);
    assign bus_valid = (state_q == StReq);
    assign bus_addr  = bus_addr_q;
    assign bus_we    = bus_we_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_lsu_bus_adapter.sv
// Scoreboard bench for lsu_bus_adapter: stimulus pushes expected bus requests and load results,
// a negedge monitor compares them whenever the bus is active.
module tb_lsu_bus_adapter;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic        mem_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        fault;
    logic        bus_valid;
    logic        bus_ready;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rd;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_rdata;
    logic        rd_pending = 1'b0;
    logic [31:0] rd_pending_val;

    lsu_bus_adapter #(.ADDR_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .fault     (fault),
        .bus_valid (bus_valid),
        .bus_ready (bus_ready),
        .bus_addr  (bus_addr),
        .bus_we    (bus_we),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: accesses described as a set of bytes starting at a base lane.
    function automatic int acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic int lane_base(input logic [2:0] f3, input logic [31:0] a);
        int sz = acc_size(f3);
        int o  = int'(a[1:0]);
        if (sz == 4) return 0;
        if (sz == 2) return (o / 2) * 2;
        return o;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] be = 4'b0000;
        int base = lane_base(f3, a);
        int sz = acc_size(f3);
        for (int i = 0; i < 4; i++) be[i] = (i >= base) && (i < base + sz);
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input logic we, input logic [2:0] f3,
                                                input logic [31:0] wd);
        logic [31:0] r = 32'd0;
        int sz = acc_size(f3);
        if (!we) return 32'd0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] brd);
        logic [31:0] v = 32'd0;
        int base = lane_base(f3, a);
        int sz = acc_size(f3);
        for (int k = 0; k < sz; k++) v[8*k +: 8] = brd[8*(base+k) +: 8];
        if (sz < 4 && !f3[2] && v[8*sz-1]) begin
            for (int k = 8 * sz; k < 32; k++) v[k] = 1'b1;
        end
        return v;
    endfunction

    function automatic bit model_misaligned(input logic [2:0] f3, input logic [31:0] a);
        int sz = acc_size(f3);
        return (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
    endfunction

    // Monitor: every active bus cycle must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rd_pending) begin
            check("rdata", rdata, rd_pending_val);
            check("fault_on_bus_access", 32'(fault), 32'd0);
            rd_pending = 1'b0;
        end
        if (bus_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_bus_valid", 32'(bus_valid), 32'd0);
            end else begin
                check("bus_addr", bus_addr, exp_q[0].addr);
                check("bus_we", 32'(bus_we), 32'(exp_q[0].we));
                check("bus_be", 32'(bus_be), 32'(exp_q[0].be));
                check("bus_wdata", bus_wdata, exp_q[0].wdata);
                if (bus_ready) begin
                    rd_pending_val = exp_q[0].rd;
                    rd_pending     = 1'b1;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Called and returns at posedge+1; mem_req stays high through DONE like a stalled core.
    task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] brd, input int waits);
        exp_t e;
        bit   mis = 1'b0;
        int   nst = 0;
        int   exp_st;
`ifdef LSU_MISALIGN_TRAP_EN
        mis = model_misaligned(f3, a);
`endif
        if (mis) begin
            model_rdata = 32'd0;
        end else if (!we) begin
            model_rdata = model_load(f3, a, brd);
        end
        e.addr  = {a[31:2], 2'b00};
        e.we    = we;
        e.be    = model_be(f3, a);
        e.wdata = model_wdata(we, f3, wd);
        e.rd    = model_rdata;
        if (!mis) exp_q.push_back(e);
        exp_st  = mis ? 1 : waits + 2;

        mem_req = 1'b1;
        mem_we  = we;
        funct3  = f3;
        addr    = a;
        wdata   = wd;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (!stall) break;
            nst++;
            @(posedge clk);
            #1;
            bus_ready = (c == waits);
            bus_rdata = brd;
        end
        check("stall_cycles", 32'(nst), 32'(exp_st));
        if (mis) begin
            check("misalign_fault", 32'(fault), 32'd1);
            check("misalign_rdata", rdata, 32'd0);
        end
        @(posedge clk);
        #1;
        mem_req   = 1'b0;
        bus_ready = 1'b0;
        bus_rdata = $urandom;
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] f3_tab[8];
        f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        reset = 1'b1;
        mem_req = 1'b0;
        mem_we = 1'b0;
        funct3 = 3'b000;
        addr = 32'd0;
        wdata = 32'd0;
        bus_ready = 1'b0;
        bus_rdata = 32'd0;
        model_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_bus_valid", 32'(bus_valid), 32'd0);
        check("rst_bus_we", 32'(bus_we), 32'd0);
        check("rst_bus_be", 32'(bus_be), 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        do_access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0);
        do_access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 3);
        do_access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 3);
        do_access(1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 1);
        do_access(1'b0, 3'b001, 32'h102, 32'h0, 32'h8001FFFF, 0);
        do_access(1'b0, 3'b001, 32'h101, 32'h0, 32'h8001FFFF, 0);
        do_access(1'b0, 3'b101, 32'h202, 32'h0, 32'hC0DE7777, 2);

        // Reset while a load waits in REQ; a late bus_ready must be ignored.
        do_access(1'b0, 3'b010, 32'h300, 32'h0, 32'h5555AAAA, 0);
        mem_req = 1'b1;
        mem_we  = 1'b0;
        funct3  = 3'b010;
        addr    = 32'h400;
        begin
            exp_t e;
            e.addr = 32'h400; e.we = 1'b0; e.be = 4'b1111; e.wdata = 32'd0; e.rd = 32'd0;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset   = 1'b1;
        mem_req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        model_rdata = 32'd0;
        bus_ready = 1'b1;
        bus_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        check("rstreq_bus_valid", 32'(bus_valid), 32'd0);
        check("rstreq_stall", 32'(stall), 32'd0);
        check("rstreq_rdata", rdata, 32'd0);
        @(posedge clk);
        #1;
        bus_ready = 1'b0;
        @(negedge clk);
        check("late_ready_rdata", rdata, 32'd0);
        check("late_ready_valid", 32'(bus_valid), 32'd0);
        @(posedge clk);
        #1;

        for (int n = 0; n < 300; n++) begin
            logic [2:0] f3;
            f3 = f3_tab[$urandom_range(0, 7)];
            do_access(1'($urandom), f3, $urandom, $urandom, $urandom, $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_bus_adapter.md
Name: lsu_bus_adapter

Overview:
- Load/store unit directly downstream of the single-cycle RV32I datapath.
- Consumes the datapath's ALU result (address), rs2 write data and the decoded memory controls, and produces the ReadData word that feeds the result mux.
- Converts byte/halfword/word accesses into a word-aligned valid/ready bus transaction with byte enables.
- Stalls the core until the transaction completes, and sign- or zero-extends load data.

Parameters:
- ADDR_W, 32, address and bus address width in bits (min 3).

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  synchronous, active-high reset
- mem_req  in  1  current instruction is a load or store (combinational from decoder)
- mem_we  in  1  1 = store, 0 = load
- funct3  in  3  000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- addr  in  ADDR_W  byte address (ALUResult)
- wdata  in  32  store data (rs2, WriteData)
- rdata  out  32  extended load data (ReadData to result mux)
- stall  out  1  hold PC and suppress RegWrite
- fault  out  1  misaligned-access pulse (see Optional Feature)
- bus_valid  out  1  request valid
- bus_ready  in  1  slave accepts/completes request
- bus_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
- bus_we  out  1  write strobe
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_rdata  in  32  read data, valid in the bus_ready cycle

Behaviour:
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - On mem_req=1: latch addr, wdata, funct3, mem_we; compute be and lane data; go to REQ.
  - On mem_req=0: stay in IDLE.
- REQ:
  - bus_valid=1; bus_addr, bus_we, bus_be and bus_wdata come from registers and stay stable until bus_ready.
  - On bus_ready=1: capture the extended load result into the rdata register (loads only; stores leave rdata unchanged), then go to DONE.
- DONE:
  - Lasts exactly one cycle, then always returns to IDLE.
  - mem_req seen in DONE is ignored: it is the same instruction, and the PC advances at the end of DONE.
- stall = (IDLE & mem_req) | REQ.
  - Minimum access: IDLE, REQ with bus_ready=1, DONE, giving 2 stall cycles.
  - Each wait cycle in REQ adds one stall cycle.
- rdata is registered and holds its value until the next load completes.
- Sizing, with off = addr[1:0]:
  - Byte: be = 4'b0001<<off; bus_wdata = {4{wdata[7:0]}}.
  - Half: be = off[1] ? 4'b1100 : 4'b0011; bus_wdata = {2{wdata[15:0]}}.
  - Word: be = 4'b1111; bus_wdata = wdata.
  - funct3 values 011, 110 and 111 are treated as word; no fault.
- Load extraction:
  - Byte = bus_rdata[8*off +: 8]; half = bus_rdata[16*off[1] +: 16].
  - funct3[2]=0 sign-extends; funct3[2]=1 zero-extends.
- bus_we is registered from mem_we; loads drive bus_wdata=0.
- Reset values: state=IDLE; rdata=0; bus_valid=0; bus_we=0; bus_be=0; bus_addr=0; bus_wdata=0; fault=0. stall=0 unless mem_req is high.
- Reset during REQ: bus_valid drops at that edge and the transaction is abandoned; any late bus_ready is ignored.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - Misalignment is checked in IDLE: a half access with addr[0]=1, or a word access with addr[1:0]!=0.
  - A misaligned access goes IDLE->DONE directly, with no bus_valid and no write.
  - fault=1 for the single DONE cycle; rdata is loaded with 0; stall lasts 1 cycle.
- Not defined:
  - fault is tied to 0.
  - Half accesses ignore addr[0] (lane chosen by addr[1]); word accesses ignore addr[1:0].

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, bus_ready high in the first REQ cycle -> bus_addr=0x100, bus_be=1111, bus_we=1, bus_wdata=0xDEADBEEF; stall high 2 cycles; DONE on the 3rd; rdata unchanged.
- LB addr=0x103, bus_rdata=0x80FF1234, bus_ready after 3 wait cycles -> bus_valid held 4 cycles with stable outputs; rdata=0xFFFFFF80; stall 5 cycles. Repeating as LBU gives rdata=0x00000080.
- SH addr=0x102, wdata=0x1234ABCD -> bus_be=1100, bus_wdata=0xABCDABCD. LH addr=0x102 with bus_rdata=0x8001FFFF -> rdata=0xFFFF8001.
- LH addr=0x101:
  - With LSU_MISALIGN_TRAP_EN: no bus_valid; fault=1 for one cycle; rdata=0; stall 1 cycle.
  - Without: bus_be=0011 and rdata from the low half; fault stays 0.
- reset=1 while in REQ with bus_ready=0 -> next cycle bus_valid=0, state IDLE, rdata=0; a bus_ready the following cycle has no effect.
- mem_req held high through DONE -> no second transaction. Then a new mem_req in the following IDLE cycle -> bus_valid rises one cycle later.
